gunshot_locator: RTL and testbench

GUNSHOT_LOCATOR -- requirements
Module: gunshot_locator

---
 rtl/gunshot_pkg.sv | 24 ++
 rtl/gsl_peak_select.sv | 48 ++++
 rtl/gunshot_locator.sv | 163 ++++++++++++++++
 tb/tb_gunshot_locator.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gunshot_pkg.sv
// Shared definitions for the gunshot locator: FSM encoding, default parameters
// and the flattened-bus channel slice helper.
package gunshot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WINDOW  = 2'd1,
    ST_REPORT  = 2'd2,
    ST_HOLDOFF = 2'd3
  } gsl_state_e;

  localparam int DEF_N_CH      = 6;
  localparam int DEF_DW        = 16;
  localparam int DEF_THRESHOLD = 32'h0000_0A00;
  localparam int DEF_WIN_LEN   = 64;
  localparam int DEF_HOLDOFF   = 1024;
  localparam int CNT_W         = 16;

  // LSB position of channel ch inside a flattened bus of dw-bit samples.
  function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned dw);
    return ch * dw;
  endfunction

endpackage

// File: rtl/gsl_peak_select.sv
// Combinational per-sample analysis: threshold crossing set, lowest crossing
// channel, and the largest crossing sample with its (lowest) channel index.
module gsl_peak_select
  import gunshot_pkg::*;
#(
  parameter int            N_CH      = DEF_N_CH,
  parameter int            DW        = DEF_DW,
  parameter logic [DW-1:0] THRESHOLD = DW'(DEF_THRESHOLD),
  localparam int           CW        = $clog2(N_CH)
) (
  input  logic [N_CH*DW-1:0] mic_data,
  output logic               any_cross,
  output logic [N_CH-1:0]    cross_mask,
  output logic [CW-1:0]      first_ch,
  output logic [DW-1:0]      max_val,
  output logic [CW-1:0]      max_ch
);

  logic [DW-1:0] samp [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_slice
    assign samp[g] = mic_data[ch_lsb(g, DW) +: DW];
  end

  // Ascending scan with strict compare keeps the lowest index on ties.
  always_comb begin
    any_cross  = 1'b0;
    cross_mask = '0;
    first_ch   = '0;
    max_val    = '0;
    max_ch     = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (samp[k] > THRESHOLD) begin
        cross_mask[k] = 1'b1;
        if (!any_cross) begin
          first_ch = CW'(k);
          max_val  = samp[k];
          max_ch   = CW'(k);
        end else if (samp[k] > max_val) begin
          max_val = samp[k];
          max_ch  = CW'(k);
        end
        any_cross = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gunshot_locator.sv
// Gunshot event locator: opens a capture window on the first threshold crossing,
// reports earliest channel, peak and crossing mask, then holds off re-arming.
module gunshot_locator
  import gunshot_pkg::*;
#(
  parameter int            N_CH      = DEF_N_CH,
  parameter int            DW        = DEF_DW,
  parameter logic [DW-1:0] THRESHOLD = DW'(DEF_THRESHOLD),
  parameter int            WIN_LEN   = DEF_WIN_LEN,
  parameter int            HOLDOFF   = DEF_HOLDOFF,
  localparam int           CW        = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic [N_CH*DW-1:0] mic_data,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [CW-1:0]      evt_first_ch,
  output logic [CW-1:0]      evt_peak_ch,
  output logic [DW-1:0]      evt_peak,
  output logic [N_CH-1:0]    evt_ch_mask,
  output logic               evt_overrun,
  output logic               busy
);

  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WIN_LEN);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF);

  gsl_state_e        state_q, state_d;
  logic [CNT_W-1:0]  win_cnt_q;
  logic [CNT_W-1:0]  hold_cnt_q;
  logic [CW-1:0]     first_ch_q;
  logic [CW-1:0]     peak_ch_q;
  logic [DW-1:0]     peak_q;
  logic [N_CH-1:0]   mask_q;
  logic              ovr_pend_q;
  logic              ovr_rpt_q;

  logic              any_cross;
  logic [N_CH-1:0]   sel_mask;
  logic [CW-1:0]     sel_first;
  logic [DW-1:0]     sel_max;
  logic [CW-1:0]     sel_max_ch;

  logic              smp_cross;
  logic              start_evt;
  logic              win_adv;
  logic              hold_adv;
  logic              handshake;
  logic              ignored;
  logic              rpt_enter;

  gsl_peak_select #(
    .N_CH      (N_CH),
    .DW        (DW),
    .THRESHOLD (THRESHOLD)
  ) u_peak_select (
    .mic_data   (mic_data),
    .any_cross  (any_cross),
    .cross_mask (sel_mask),
    .first_ch   (sel_first),
    .max_val    (sel_max),
    .max_ch     (sel_max_ch)
  );

  assign smp_cross = sample_valid & any_cross;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_evt = 1'b0;
    win_adv   = 1'b0;
    hold_adv  = 1'b0;
    handshake = 1'b0;
    ignored   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (smp_cross) begin
          start_evt = 1'b1;
          state_d   = (WIN_LAST == CNT_W'(1)) ? ST_REPORT : ST_WINDOW;
        end
      end
      ST_WINDOW: begin
        if (sample_valid) begin
          win_adv = 1'b1;
          if (win_cnt_q + CNT_W'(1) == WIN_LAST) state_d = ST_REPORT;
        end
      end
      ST_REPORT: begin
        // A crossing coinciding with the handshake still belongs to this record's dead time.
        ignored = smp_cross;
        if (evt_ready) begin
          handshake = 1'b1;
          state_d   = (HOLD_LAST == '0) ? ST_IDLE : ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        ignored = smp_cross;
        if (sample_valid) begin
          hold_adv = 1'b1;
          if (hold_cnt_q + CNT_W'(1) == HOLD_LAST) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rpt_enter = (state_d == ST_REPORT) && (state_q != ST_REPORT);

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt_q  <= '0;
      hold_cnt_q <= '0;
      first_ch_q <= '0;
      peak_ch_q  <= '0;
      peak_q     <= '0;
      mask_q     <= '0;
      ovr_pend_q <= 1'b0;
      ovr_rpt_q  <= 1'b0;
    end else begin
      if (start_evt) begin
        first_ch_q <= sel_first;
        peak_q     <= sel_max;
        peak_ch_q  <= sel_max_ch;
        mask_q     <= sel_mask;
        win_cnt_q  <= CNT_W'(1);
      end else if (win_adv) begin
        win_cnt_q <= win_cnt_q + CNT_W'(1);
        mask_q    <= mask_q | sel_mask;
        if (any_cross && (sel_max > peak_q)) begin
          peak_q    <= sel_max;
          peak_ch_q <= sel_max_ch;
        end
      end

      if (handshake)     hold_cnt_q <= '0;
      else if (hold_adv) hold_cnt_q <= hold_cnt_q + CNT_W'(1);

      // Ignored crossings accumulate until the next record opens, which snapshots them.
      if (rpt_enter) begin
        ovr_rpt_q  <= ovr_pend_q;
        ovr_pend_q <= 1'b0;
      end else begin
        if (handshake) ovr_rpt_q  <= 1'b0;
        if (ignored)   ovr_pend_q <= 1'b1;
      end
    end
  end

  assign evt_valid    = (state_q == ST_REPORT);
  assign busy         = (state_q != ST_IDLE);
  assign evt_first_ch = first_ch_q;
  assign evt_peak_ch  = peak_ch_q;
  assign evt_peak     = peak_q;
  assign evt_ch_mask  = mask_q;
  assign evt_overrun  = ovr_rpt_q;

endmodule

// File: tb/tb_gunshot_locator.sv
// Bench for gunshot_locator: vector table, directed corner sequences and a
// randomized run against a window-list reference model.
module tb_gunshot_locator;

  localparam int N    = 6;
  localparam int DW   = 16;
  localparam int WIN  = 4;
  localparam int HOLD = 8;
  localparam logic [15:0] THR = 16'h0A00;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [95:0] mic_data;
  logic        evt_ready;

  logic        evt_valid, evt_overrun, busy;
  logic [2:0]  evt_first_ch, evt_peak_ch;
  logic [15:0] evt_peak;
  logic [5:0]  evt_ch_mask;

  logic        b_valid, b_overrun, b_busy;
  logic [2:0]  b_first_ch, b_peak_ch;
  logic [15:0] b_peak;
  logic [5:0]  b_mask;

  gunshot_locator #(.N_CH(N), .DW(DW), .WIN_LEN(WIN), .HOLDOFF(HOLD)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .mic_data(mic_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_first_ch(evt_first_ch),
    .evt_peak_ch(evt_peak_ch), .evt_peak(evt_peak), .evt_ch_mask(evt_ch_mask),
    .evt_overrun(evt_overrun), .busy(busy)
  );

  gunshot_locator #(.N_CH(N), .DW(DW), .WIN_LEN(1), .HOLDOFF(0)) dut_min (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .mic_data(mic_data),
    .evt_valid(b_valid), .evt_ready(evt_ready), .evt_first_ch(b_first_ch),
    .evt_peak_ch(b_peak_ch), .evt_peak(b_peak), .evt_ch_mask(b_mask),
    .evt_overrun(b_overrun), .busy(b_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] chv(input int ch, input logic [15:0] v);
    logic [95:0] r;
    r = '0;
    r[ch*16 +: 16] = v;
    return r;
  endfunction

  task automatic cyc(input logic v, input logic [95:0] d, input logic r);
    sample_valid = v;
    mic_data     = d;
    evt_ready    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, '0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic check_record(input string tag, input logic [2:0] f, input logic [2:0] pc,
                              input logic [15:0] pk, input logic [5:0] m, input logic o);
    check({tag, ".valid"},   32'(evt_valid), 32'(1));
    check({tag, ".first"},   32'(evt_first_ch), 32'(f));
    check({tag, ".peak_ch"}, 32'(evt_peak_ch), 32'(pc));
    check({tag, ".peak"},    32'(evt_peak), 32'(pk));
    check({tag, ".mask"},    32'(evt_ch_mask), 32'(m));
    check({tag, ".ovr"},     32'(evt_overrun), 32'(o));
  endtask

  // n valid holdoff samples; sample number cross_at (1-based) carries a crossing
  task automatic hold_samples(input int n, input int cross_at);
    for (int i = 1; i <= n; i++)
      cyc(1'b1, (i == cross_at) ? chv(2, 16'h2222) : 96'd0, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        v;
    logic [95:0] d;
    logic        r;
    logic        e_valid;
    logic        e_busy;
    logic        rec;
    logic [2:0]  e_first;
    logic [2:0]  e_pch;
    logic [15:0] e_peak;
    logic [5:0]  e_mask;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic v, input logic [95:0] d, input logic r,
                              input logic ev, input logic eb, input logic rec,
                              input logic [2:0] f, input logic [2:0] pc,
                              input logic [15:0] pk, input logic [5:0] m);
    vec_t x;
    x.v = v; x.d = d; x.r = r; x.e_valid = ev; x.e_busy = eb; x.rec = rec;
    x.e_first = f; x.e_pch = pc; x.e_peak = pk; x.e_mask = m;
    vecs.push_back(x);
  endfunction

  // ---------------- reference model ----------------
  localparam int M_ARMED = 0, M_COLLECT = 1, M_SHOW = 2, M_DEAD = 3;
  logic [95:0] win_q[$];
  int          m_mode, m_dead, m_ignored;
  logic [2:0]  m_first, m_pch;
  logic [15:0] m_peak;
  logic [5:0]  m_mask;
  logic        m_ovr;

  function automatic logic [5:0] xset(input logic [95:0] d);
    logic [5:0] s;
    s = '0;
    for (int k = 0; k < N; k++) s[k] = (d[k*16 +: 16] > THR);
    return s;
  endfunction

  function automatic void model_reset();
    win_q.delete();
    m_mode = M_ARMED; m_dead = 0; m_ignored = 0;
    m_first = '0; m_pch = '0; m_peak = '0; m_mask = '0; m_ovr = 1'b0;
  endfunction

  // Summarise the whole window: earliest sample's lowest crossing channel,
  // first-seen maximum in time/channel order, union of crossings.
  function automatic void summarize();
    logic [5:0]  s0;
    logic [15:0] s;
    s0 = xset(win_q[0]);
    for (int k = N - 1; k >= 0; k--) if (s0[k]) m_first = 3'(k);
    m_peak = '0; m_mask = '0; m_pch = '0;
    foreach (win_q[t]) begin
      for (int k = 0; k < N; k++) begin
        s = win_q[t][k*16 +: 16];
        if (s > THR) begin
          m_mask[k] = 1'b1;
          if (s > m_peak) begin m_peak = s; m_pch = 3'(k); end
        end
      end
    end
  endfunction

  function automatic void model_step(input logic v, input logic [95:0] d, input logic r);
    logic crossing;
    crossing = v && (xset(d) != '0);
    case (m_mode)
      M_ARMED:   if (crossing) begin win_q.delete(); win_q.push_back(d); m_mode = M_COLLECT; end
      M_COLLECT: if (v) win_q.push_back(d);
      M_SHOW: begin
        if (crossing) m_ignored++;
        if (r) begin m_ovr = 1'b0; m_dead = HOLD; m_mode = (HOLD > 0) ? M_DEAD : M_ARMED; end
      end
      default: if (v) begin
        if (crossing) m_ignored++;
        m_dead--;
        if (m_dead == 0) m_mode = M_ARMED;
      end
    endcase
    if (m_mode == M_COLLECT && win_q.size() == WIN) begin
      summarize();
      m_ovr = (m_ignored > 0);
      m_ignored = 0;
      m_mode = M_SHOW;
    end
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sample_valid = 1'b0; mic_data = '0; evt_ready = 1'b0;
    do_reset();

    check("rst.valid", 32'(evt_valid), 32'(0));
    check("rst.busy",  32'(busy), 32'(0));
    check("rst.first", 32'(evt_first_ch), 32'(0));
    check("rst.pch",   32'(evt_peak_ch), 32'(0));
    check("rst.peak",  32'(evt_peak), 32'(0));
    check("rst.mask",  32'(evt_ch_mask), 32'(0));
    check("rst.ovr",   32'(evt_overrun), 32'(0));

    // two-sample event: first on ch3, later larger peak on ch1
    add(1, chv(3, 16'h0B00), 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, '0,               0, 0, 1, 0, 0, 0, 0, 0);
    add(1, chv(1, 16'h2000), 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, '0,               0, 1, 1, 1, 3, 1, 16'h2000, 6'b001010);
    add(0, '0,               1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(1, '0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, '0,               0, 0, 0, 0, 0, 0, 0, 0);
    // simultaneous tie on ch2/ch4
    add(1, chv(2, 16'h1000) | chv(4, 16'h1000), 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, '0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, '0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, '0, 0, 1, 1, 1, 2, 2, 16'h1000, 6'b010100);
    add(1, '0, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(1, '0, 1, 0, 1, 0, 0, 0, 0, 0);
    add(1, '0, 0, 0, 0, 0, 0, 0, 0, 0);
    // later equal peak loses, invalid cycle ignored, threshold itself does not cross
    add(1, chv(5, 16'h3000), 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, chv(0, 16'h3000) | chv(2, 16'h0A01), 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, chv(4, 16'h7000), 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, '0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, chv(1, 16'h0A00), 0, 1, 1, 1, 5, 5, 16'h3000, 6'b100101);
    add(0, '0, 1, 0, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].v, vecs[i].d, vecs[i].r);
      check($sformatf("vec%0d.valid", i), 32'(evt_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d.busy", i),  32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d.ovr", i),   32'(evt_overrun), 32'(0));
      if (vecs[i].rec) begin
        check($sformatf("vec%0d.first", i), 32'(evt_first_ch), 32'(vecs[i].e_first));
        check($sformatf("vec%0d.pch", i),   32'(evt_peak_ch), 32'(vecs[i].e_pch));
        check($sformatf("vec%0d.peak", i),  32'(evt_peak), 32'(vecs[i].e_peak));
        check($sformatf("vec%0d.mask", i),  32'(evt_ch_mask), 32'(vecs[i].e_mask));
      end
    end

    // all channels exactly at threshold never trigger
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, {6{16'h0A00}}, 1'b0);
      check("thr.valid", 32'(evt_valid), 32'(0));
      check("thr.busy",  32'(busy), 32'(0));
    end

    // backpressure, ignored crossings, overrun reporting
    do_reset();
    cyc(1'b1, chv(0, 16'h1500), 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, '0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, chv(i % 6, 16'h4000 + 16'(i)), 1'b0);
      check_record($sformatf("stall%0d", i), 0, 0, 16'h1500, 6'b000001, 1'b0);
    end
    cyc(1'b0, '0, 1'b1);
    check("acc1.valid", 32'(evt_valid), 32'(0));
    check("acc1.busy",  32'(busy), 32'(1));
    hold_samples(HOLD, 5);
    check("hold1.busy", 32'(busy), 32'(0));
    cyc(1'b1, chv(4, 16'h0B00), 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, '0, 1'b0);
    check_record("ev2", 4, 4, 16'h0B00, 6'b010000, 1'b1);
    cyc(1'b0, '0, 1'b1);
    hold_samples(HOLD, 5);
    cyc(1'b1, chv(1, 16'h0C00), 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, '0, 1'b0);
    check_record("ev3", 1, 1, 16'h0C00, 6'b000010, 1'b1);
    cyc(1'b0, '0, 1'b1);
    hold_samples(HOLD, 0);
    cyc(1'b1, chv(3, 16'h0D00), 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, '0, 1'b0);
    check_record("ev4", 3, 3, 16'h0D00, 6'b001000, 1'b0);

    // reset mid-REPORT discards the record
    reset = 1'b1;
    cyc(1'b1, chv(2, 16'h5000), 1'b0);
    reset = 1'b0;
    check("rstrpt.valid", 32'(evt_valid), 32'(0));
    check("rstrpt.busy",  32'(busy), 32'(0));
    check("rstrpt.peak",  32'(evt_peak), 32'(0));

    // reset mid-WINDOW, then a clean event
    cyc(1'b1, chv(3, 16'h5000), 1'b0);
    reset = 1'b1;
    cyc(1'b1, chv(0, 16'h6000), 1'b0);
    reset = 1'b0;
    check("rstwin.busy",  32'(busy), 32'(0));
    check("rstwin.valid", 32'(evt_valid), 32'(0));
    check("rstwin.mask",  32'(evt_ch_mask), 32'(0));
    cyc(1'b1, chv(5, 16'h0C00), 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, '0, 1'b0);
    check_record("postrst", 5, 5, 16'h0C00, 6'b100000, 1'b0);

    // gaps in sample_valid do not advance the window
    do_reset();
    begin
      logic [6:0] vpat;
      vpat = 7'b1101001;
      for (int i = 0; i < 7; i++) begin
        cyc(vpat[i], (i == 0) ? chv(2, 16'h0B00) : (vpat[i] ? 96'd0 : chv(0, 16'hFFFF)), 1'b0);
        check($sformatf("gap%0d.valid", i), 32'(evt_valid), 32'(i == 6));
      end
      check("gap.peak", 32'(evt_peak), 32'(16'h0B00));
      check("gap.mask", 32'(evt_ch_mask), 32'(6'b000100));
    end

    // WIN_LEN=1 / HOLDOFF=0 instance
    do_reset();
    cyc(1'b1, chv(1, 16'h0C00), 1'b0);
    check("min1.valid", 32'(b_valid), 32'(1));
    check("min1.first", 32'(b_first_ch), 32'(1));
    check("min1.peak",  32'(b_peak), 32'(16'h0C00));
    check("min1.ovr",   32'(b_overrun), 32'(0));
    cyc(1'b1, chv(3, 16'h0D00), 1'b1);
    check("min2.valid", 32'(b_valid), 32'(0));
    check("min2.busy",  32'(b_busy), 32'(0));
    cyc(1'b1, chv(4, 16'h0E00), 1'b0);
    check("min3.valid", 32'(b_valid), 32'(1));
    check("min3.pch",   32'(b_peak_ch), 32'(4));
    check("min3.mask",  32'(b_mask), 32'(6'b010000));
    check("min3.ovr",   32'(b_overrun), 32'(1));
    cyc(1'b0, '0, 1'b1);
    check("min4.valid", 32'(b_valid), 32'(0));

    // randomized run against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      logic        v, r;
      logic [95:0] d;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < N; k++) begin
        case ($urandom_range(0, 11))
          0:       d[k*16 +: 16] = 16'($urandom_range(32'h0A01, 32'hFFFF));
          1:       d[k*16 +: 16] = THR;
          default: d[k*16 +: 16] = 16'($urandom_range(0, 32'h09FF));
        endcase
      end
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        cyc(v, d, r);
        reset = 1'b0;
        model_reset();
      end else begin
        cyc(v, d, r);
        model_step(v, d, r);
      end
      check($sformatf("rnd%0d.valid", c), 32'(evt_valid), 32'(m_mode == M_SHOW));
      check($sformatf("rnd%0d.busy", c),  32'(busy), 32'(m_mode != M_ARMED));
      check($sformatf("rnd%0d.ovr", c),   32'(evt_overrun), 32'(m_ovr));
      if (m_mode == M_SHOW) begin
        check($sformatf("rnd%0d.first", c), 32'(evt_first_ch), 32'(m_first));
        check($sformatf("rnd%0d.pch", c),   32'(evt_peak_ch), 32'(m_pch));
        check($sformatf("rnd%0d.peak", c),  32'(evt_peak), 32'(m_peak));
        check($sformatf("rnd%0d.mask", c),  32'(evt_ch_mask), 32'(m_mask));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
